mips32_fetch_queue: RTL and testbench

Instruction prefetch unit upstream of the MIPS32 pipeline's IF/ID boundary. It issues sequential word-address reads to instruction memory over a valid/ready request port and accepts in-order responses with arbitrary latency. Fetched words and their next-PC values are buffered in a small FIFO and handed to the decode side over a valid/ready port. Taken-branch redirects flush the queue and discard in-flight responses.

---
 rtl/mips32_fetch_queue.sv | 135 +++++++++++++
 tb/tb_mips32_fetch_queue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
// Instruction prefetch queue: issues sequential word reads, buffers in-order responses
// with their next-PC, and flushes on taken-branch redirects.
module mips32_fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk1,
    input  logic              rst,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [31:0]       mem_rsp_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_npc,
    output logic              fetch_stopped
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [31:0]       ir;
        logic [ADDR_W-1:0] npc;
    } entry_t;

    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] rsp_pc, rsp_pc_n;
    logic [CNT_W-1:0]  count, count_n;
    logic [CNT_W-1:0]  inflight, inflight_n;
    logic [CNT_W-1:0]  drop, drop_n;
    logic              stopped, stopped_n;
    logic [PTR_W-1:0]  rd_ptr, rd_ptr_n;
    logic [PTR_W-1:0]  wr_ptr, wr_ptr_n;
    logic              wr_en;
    entry_t            wr_entry;
    entry_t            fifo [DEPTH];

    logic [CNT_W:0]    occupancy;
    logic              req_fire;
    logic              rsp_fire;
    logic              enq;
    logic              pop;
    logic              is_hlt;

    // Queued plus in-flight words never exceed DEPTH, so an enqueue always has room.
    assign occupancy     = {1'b0, count} + {1'b0, inflight};
    assign mem_req_valid = !rst && !stopped && !redirect_valid
                           && (occupancy < (CNT_W+1)'(DEPTH));
    assign mem_req_addr  = pc;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign rsp_fire      = mem_rsp_valid && (inflight != '0);
    assign enq           = rsp_fire && (drop == '0);
    assign pop           = (count != '0) && out_ready;
    assign is_hlt        = (mem_rsp_data[31:26] == 6'b111111);
    assign wr_entry      = '{ir: mem_rsp_data, npc: rsp_pc + ADDR_W'(1)};

    assign out_valid     = (count != '0);
    assign out_ir        = fifo[rd_ptr].ir;
    assign out_npc       = 32'(fifo[rd_ptr].npc);
    assign fetch_stopped = stopped;

    // Next-state; a redirect voids any same-cycle enqueue/pop and drops every outstanding request.
    always_comb begin
        pc_n       = pc;
        rsp_pc_n   = rsp_pc;
        count_n    = count;
        drop_n     = drop;
        stopped_n  = stopped;
        rd_ptr_n   = rd_ptr;
        wr_ptr_n   = wr_ptr;
        wr_en      = 1'b0;
        inflight_n = inflight + CNT_W'(req_fire) - CNT_W'(rsp_fire);

        if (redirect_valid) begin
            pc_n      = redirect_pc;
            rsp_pc_n  = redirect_pc;
            count_n   = '0;
            rd_ptr_n  = '0;
            wr_ptr_n  = '0;
            drop_n    = inflight_n;
            stopped_n = 1'b0;
        end else begin
            if (req_fire) begin
                pc_n = pc + ADDR_W'(1);
            end
            if (rsp_fire && (drop != '0)) begin
                drop_n = drop - CNT_W'(1);
            end
            if (enq) begin
                wr_en    = 1'b1;
                wr_ptr_n = wr_ptr + PTR_W'(1);
                rsp_pc_n = rsp_pc + ADDR_W'(1);
                if (is_hlt) begin
                    stopped_n = 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + PTR_W'(1);
            end
            count_n = count + CNT_W'(enq) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            pc       <= '0;
            rsp_pc   <= '0;
            count    <= '0;
            inflight <= '0;
            drop     <= '0;
            stopped  <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo     <= '{default: '0};
        end else begin
            pc       <= pc_n;
            rsp_pc   <= rsp_pc_n;
            count    <= count_n;
            inflight <= inflight_n;
            drop     <= drop_n;
            stopped  <= stopped_n;
            rd_ptr   <= rd_ptr_n;
            wr_ptr   <= wr_ptr_n;
            if (wr_en) begin
                fifo[wr_ptr] <= wr_entry;
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Directed bench for mips32_fetch_queue: table-driven streaming/backpressure vectors
// plus hand-written redirect, HLT, wrap and mid-stream reset sequences.
module tb_mips32_fetch_queue;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b1;
    logic [9:0]  mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [9:0]  redirect_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_ir;
    logic [31:0] out_npc;
    logic        fetch_stopped;

    always #5 clk1 = ~clk1;

    mips32_fetch_queue #(.DEPTH(4), .ADDR_W(10)) dut (
        .clk1          (clk1),
        .rst           (rst),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_ir        (out_ir),
        .out_npc       (out_npc),
        .fetch_stopped (fetch_stopped)
    );

    typedef struct {
        logic [9:0] addr;
        int         due;
    } pend_t;

    typedef struct {
        logic        rst;
        logic        ordy;
        logic        chk;
        logic        ev;
        logic [9:0]  ea;
        logic        eov;
        logic [31:0] eir;
        logic [31:0] enpc;
    } vec_t;

    logic [31:0] mem [1024];
    pend_t       q[$];
    vec_t        tbl[$];
    int          cyc = 0;
    int          lat = 1;
    logic        rsp_hold = 1'b0;
    int          n_chk = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mw(input int a);
        return 32'h2801_000A + 32'(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: memory model records accepted requests and returns them in order after lat cycles.
    task automatic tick();
        logic       acc;
        logic       rv;
        logic [9:0] a;
        pend_t      p;
        acc = mem_req_valid && mem_req_ready;
        a   = mem_req_addr;
        rv  = mem_rsp_valid;
        @(posedge clk1);
        if (rv) void'(q.pop_front());
        if (acc) begin
            p.addr = a;
            p.due  = cyc + lat;
            q.push_back(p);
        end
        cyc++;
        @(negedge clk1);
        if (!rsp_hold && q.size() > 0 && q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = mem[q[0].addr];
        end else begin
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        repeat (5) tick();
        rst = 1'b0;
    endtask

    task automatic add(input logic r, input logic o, input logic c, input logic ev,
                       input int ea, input logic eov, input logic [31:0] eir, input int enpc);
        vec_t v;
        v.rst = r; v.ordy = o; v.chk = c; v.ev = ev; v.ea = 10'(ea);
        v.eov = eov; v.eir = eir; v.enpc = 32'(enpc);
        tbl.push_back(v);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = mw(i);

        // reset
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);
        // streaming, L=1
        add(0, 1, 1, 1, 0, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 1, 1, 1, k + 2, 1, mw(k), k + 1);
        // reset again
        add(1, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 0, 0, 0);
        // backpressure, then release
        add(0, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 2, 1, mw(0), 1);
        add(0, 0, 1, 1, 3, 1, mw(0), 1);
        for (int k = 0; k < 3; k++) add(0, 0, 1, 0, 4, 1, mw(0), 1);
        add(0, 1, 1, 0, 4, 1, mw(0), 1);
        add(0, 1, 1, 1, 4, 1, mw(1), 2);
        add(0, 1, 1, 1, 5, 1, mw(2), 3);
        add(0, 1, 1, 1, 6, 1, mw(3), 4);
        add(0, 1, 1, 1, 7, 1, mw(4), 5);

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst;
            out_ready = tbl[i].ordy;
            #1;
            check($sformatf("row%0d req_valid", i), 32'(mem_req_valid), 32'(tbl[i].ev));
            if (tbl[i].chk) begin
                check($sformatf("row%0d req_addr", i), 32'(mem_req_addr), 32'(tbl[i].ea));
                check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].eov));
                check($sformatf("row%0d out_ir", i), out_ir, tbl[i].eir);
                check($sformatf("row%0d out_npc", i), out_npc, tbl[i].enpc);
                check($sformatf("row%0d stopped", i), 32'(fetch_stopped), 32'd0);
            end
            tick();
        end

        // redirect with responses in flight, L=3
        lat = 3; out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("redir r%0d req_valid", k), 32'(mem_req_valid), (k < 4) ? 32'd1 : 32'd0);
            if (k < 4) check($sformatf("redir r%0d req_addr", k), 32'(mem_req_addr), 32'(k));
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 10'h020;
        #1;
        check("redir cycle out_valid", 32'(out_valid), 32'd1);
        check("redir cycle req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("redir r6 out_valid", 32'(out_valid), 32'd0);
        check("redir r6 req_valid", 32'(mem_req_valid), 32'd1);
        check("redir r6 req_addr", 32'(mem_req_addr), 32'h20);
        tick();
        for (int k = 7; k < 10; k++) begin
            #1;
            check($sformatf("redir r%0d out_valid", k), 32'(out_valid), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        check("redir first out_valid", 32'(out_valid), 32'd1);
        check("redir first out_ir", out_ir, mem[32'h20]);
        check("redir first out_npc", out_npc, 32'h21);
        tick();
        #1;
        check("redir second out_ir", out_ir, mem[32'h21]);
        check("redir second out_npc", out_npc, 32'h22);
        tick();

        // HLT stops fetch; redirect restarts it
        lat = 1; out_ready = 1'b1;
        mem[2] = 32'hFC00_0000;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("hlt h%0d req_addr", k), 32'(mem_req_addr), 32'(k));
            check($sformatf("hlt h%0d req_valid", k), 32'(mem_req_valid), 32'd1);
            tick();
        end
        #1;
        check("hlt h4 stopped", 32'(fetch_stopped), 32'd1);
        check("hlt h4 req_valid", 32'(mem_req_valid), 32'd0);
        check("hlt h4 out_ir", out_ir, 32'hFC00_0000);
        check("hlt h4 out_npc", out_npc, 32'd3);
        tick();
        #1;
        check("hlt h5 out_ir", out_ir, mw(3));
        check("hlt h5 req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        #1;
        check("hlt h6 out_valid", 32'(out_valid), 32'd0);
        check("hlt h6 req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b1; redirect_pc = 10'h000;
        #1;
        check("hlt redirect req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("hlt restart stopped", 32'(fetch_stopped), 32'd0);
        check("hlt restart req_valid", 32'(mem_req_valid), 32'd1);
        check("hlt restart req_addr", 32'(mem_req_addr), 32'd0);
        tick();
        mem[2] = mw(2);

        // address wrap at the top of memory
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 10'h3FF;
        #1;
        check("wrap redirect req_valid", 32'(mem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check("wrap w1 req_addr", 32'(mem_req_addr), 32'h3FF);
        tick();
        #1;
        check("wrap w2 req_addr", 32'(mem_req_addr), 32'h000);
        tick();
        #1;
        check("wrap w3 out_ir", out_ir, mw(1023));
        check("wrap w3 out_npc", out_npc, 32'h0);
        tick();
        #1;
        check("wrap w4 out_ir", out_ir, mw(0));
        check("wrap w4 out_npc", out_npc, 32'h1);
        tick();

        // reset with count=3, inflight=1; the late response must be ignored
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("rstmid m%0d req_addr", k), 32'(mem_req_addr), 32'(k));
            tick_hold_before(k == 3);
        end
        rst = 1'b1;
        #1;
        check("rstmid m4 out_valid", 32'(out_valid), 32'd1);
        tick();
        #1;
        check("rstmid m5 out_valid", 32'(out_valid), 32'd0);
        check("rstmid m5 req_valid", 32'(mem_req_valid), 32'd0);
        rsp_hold = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("rstmid m6 out_valid", 32'(out_valid), 32'd0);
        check("rstmid m6 req_valid", 32'(mem_req_valid), 32'd1);
        check("rstmid m6 req_addr", 32'(mem_req_addr), 32'd0);
        tick();
        #1;
        check("rstmid late rsp ignored", 32'(out_valid), 32'd0);
        tick();
        #1;
        check("rstmid m8 out_valid", 32'(out_valid), 32'd1);
        check("rstmid m8 out_ir", out_ir, mw(0));
        check("rstmid m8 out_npc", out_npc, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic tick_hold_before(input logic hold);
        if (hold) rsp_hold = 1'b1;
        tick();
    endtask

endmodule
